// File: rtl/aes_selftest_sequencer.sv
// rtl/aes_selftest_sequencer.sv - known-answer self-test sequencer for an AES core
//
// Walks a ROM of known-answer vectors for every key size enabled in NK_MASK.
// Each vector is first encrypted and then decrypted by the attached core, and
// both results are checked against the ROM contents.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   start             one-cycle pulse that starts a run (ignored while busy)
//   vec_nk, vec_addr  ROM key-size select and vector index
//   vec_key/pt/ct     ROM data: left-aligned key, plaintext, expected ciphertext
//   core_*            start/done handshake, mode, key size, key and data to the core
//   busy, done        run in progress / run finished (done holds until next start)
//   pass_encrypt/decrypt, fail_count, fail_vec, timeout   run results
module aes_selftest_sequencer #(
    parameter int         NUM_VECTORS = 4,
    parameter int         ADDR_W      = 2,
    parameter logic [2:0] NK_MASK     = 3'b111,
    parameter int         TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [1:0]        vec_nk,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic [255:0]      vec_key,
    input  logic [127:0]      vec_pt,
    input  logic [127:0]      vec_ct,
    output logic              core_start,
    output logic              core_decrypt,
    output logic [1:0]        core_nk,
    output logic [255:0]      core_key,
    output logic [127:0]      core_din,
    input  logic              core_done,
    input  logic [127:0]      core_dout,
    output logic              busy,
    output logic              done,
    output logic              pass_encrypt,
    output logic              pass_decrypt,
    output logic [7:0]        fail_count,
    output logic [ADDR_W-1:0] fail_vec,
    output logic              timeout
);

    localparam int                CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_VECTORS - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, ENC_GO, ENC_WAIT, DEC_GO, DEC_WAIT, NEXT, FIN
    } state_t;

    state_t state, state_next;

    logic [127:0]     pt_r;
    logic [127:0]     ct_r;
    logic [CNT_W-1:0] wait_cnt;
    logic             enc_failed;
    logic             dec_failed;
    logic             any_failed;

    logic [1:0]   first_nk;
    logic [1:0]   nk_next;
    logic         nk_more;
    logic         in_wait;
    logic         got_done;
    logic         expired;
    logic         op_end;
    logic         op_fail;
    logic [127:0] expected;

    // Lowest enabled key size starts the run.
    always_comb begin
        first_nk = 2'd0;
        if (NK_MASK[0])      first_nk = 2'd0;
        else if (NK_MASK[1]) first_nk = 2'd1;
        else if (NK_MASK[2]) first_nk = 2'd2;
    end

    // Next enabled key size above the current one, if any.
    always_comb begin
        nk_more = 1'b0;
        nk_next = vec_nk;
        case (vec_nk)
            2'd0: begin
                if (NK_MASK[1]) begin
                    nk_more = 1'b1;
                    nk_next = 2'd1;
                end else if (NK_MASK[2]) begin
                    nk_more = 1'b1;
                    nk_next = 2'd2;
                end
            end
            2'd1: begin
                if (NK_MASK[2]) begin
                    nk_more = 1'b1;
                    nk_next = 2'd2;
                end
            end
            default: ;
        endcase
    end

    // A done arriving in the final wait cycle wins over the timeout.
    assign in_wait  = (state == ENC_WAIT) || (state == DEC_WAIT);
    assign got_done = in_wait && core_done;
    assign expired  = in_wait && !core_done && (wait_cnt == CNT_LAST);
    assign op_end   = got_done || expired;
    assign expected = (state == DEC_WAIT) ? pt_r : ct_r;
    assign op_fail  = expired || (got_done && (core_dout != expected));

    assign core_din = core_decrypt ? ct_r : pt_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        core_start = 1'b0;
        busy       = (state != IDLE) && (state != FIN);
        case (state)
            IDLE:     if (start) state_next = (NK_MASK == 3'b000) ? FIN : FETCH;
            FETCH:    state_next = ENC_GO;
            ENC_GO: begin
                core_start = 1'b1;
                state_next = ENC_WAIT;
            end
            ENC_WAIT: if (op_end) state_next = DEC_GO;
            DEC_GO: begin
                core_start = 1'b1;
                state_next = DEC_WAIT;
            end
            DEC_WAIT: if (op_end) state_next = NEXT;
            NEXT:     state_next = ((vec_addr != ADDR_LAST) || nk_more) ? FETCH : FIN;
            FIN:      state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vec_nk       <= 2'd0;
            vec_addr     <= '0;
            core_decrypt <= 1'b0;
            core_nk      <= 2'd0;
            core_key     <= '0;
            pt_r         <= '0;
            ct_r         <= '0;
            wait_cnt     <= '0;
            done         <= 1'b0;
            pass_encrypt <= 1'b0;
            pass_decrypt <= 1'b0;
            fail_count   <= 8'd0;
            fail_vec     <= '0;
            timeout      <= 1'b0;
            enc_failed   <= 1'b0;
            dec_failed   <= 1'b0;
            any_failed   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec_nk       <= first_nk;
                        vec_addr     <= '0;
                        done         <= 1'b0;
                        pass_encrypt <= 1'b0;
                        pass_decrypt <= 1'b0;
                        fail_count   <= 8'd0;
                        fail_vec     <= '0;
                        timeout      <= 1'b0;
                        enc_failed   <= 1'b0;
                        dec_failed   <= 1'b0;
                        any_failed   <= 1'b0;
                        // With no key sizes enabled the run is vacuously passing.
                        if (NK_MASK == 3'b000) begin
                            done         <= 1'b1;
                            pass_encrypt <= 1'b1;
                            pass_decrypt <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    core_key     <= vec_key;
                    pt_r         <= vec_pt;
                    ct_r         <= vec_ct;
                    core_nk      <= vec_nk;
                    core_decrypt <= 1'b0;
                end
                ENC_GO, DEC_GO: wait_cnt <= '0;
                ENC_WAIT, DEC_WAIT: begin
                    if (!op_end) wait_cnt <= wait_cnt + 1'b1;
                    if (expired) timeout <= 1'b1;
                    if (op_fail) begin
                        if (state == ENC_WAIT) enc_failed <= 1'b1;
                        else                   dec_failed <= 1'b1;
                        if (fail_count != 8'hff) fail_count <= fail_count + 8'd1;
                        if (!any_failed) begin
                            any_failed <= 1'b1;
                            fail_vec   <= vec_addr;
                        end
                    end
                    // Mode flips only once the encrypt operation is finished.
                    if (op_end && (state == ENC_WAIT)) core_decrypt <= 1'b1;
                end
                NEXT: begin
                    if (vec_addr != ADDR_LAST) begin
                        vec_addr <= vec_addr + 1'b1;
                    end else begin
                        vec_addr <= '0;
                        if (nk_more) begin
                            vec_nk <= nk_next;
                        end else begin
                            done         <= 1'b1;
                            pass_encrypt <= !enc_failed;
                            pass_decrypt <= !dec_failed;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_selftest_sequencer.sv
// tb/tb_aes_selftest_sequencer.sv - directed self-checking bench for aes_selftest_sequencer
module tb_aes_selftest_sequencer;

    localparam int LAT = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int vectors = 0;
    int errs = 0;

    // ---------------- DUT A: AES-128 only, one vector ----------------
    logic         start_a = 1'b0;
    logic [1:0]   vec_nk_a;
    logic [1:0]   vec_addr_a;
    logic [255:0] vec_key_a;
    logic [127:0] vec_pt_a, vec_ct_a;
    logic         core_start_a, core_decrypt_a;
    logic [1:0]   core_nk_a;
    logic [255:0] core_key_a;
    logic [127:0] core_din_a;
    logic         core_done_a;
    logic         mdone_a = 1'b0;
    logic         spur_a = 1'b0;
    logic [127:0] core_dout_a = '0;
    logic         busy_a, done_a, pass_e_a, pass_d_a, timeout_a;
    logic [7:0]   fail_count_a;
    logic [1:0]   fail_vec_a;

    // ---------------- DUT B: all key sizes, four vectors ----------------
    logic         start_b = 1'b0;
    logic [1:0]   vec_nk_b;
    logic [1:0]   vec_addr_b;
    logic [255:0] vec_key_b;
    logic [127:0] vec_pt_b, vec_ct_b;
    logic         core_start_b, core_decrypt_b;
    logic [1:0]   core_nk_b;
    logic [255:0] core_key_b;
    logic [127:0] core_din_b;
    logic         core_done_b = 1'b0;
    logic [127:0] core_dout_b = '0;
    logic         busy_b, done_b, pass_e_b, pass_d_b, timeout_b;
    logic [7:0]   fail_count_b;
    logic [1:0]   fail_vec_b;

    logic corrupt_b = 1'b0;
    logic hang_b = 1'b0;

    assign core_done_a = mdone_a | spur_a;

    aes_selftest_sequencer #(.NUM_VECTORS(1), .ADDR_W(2), .NK_MASK(3'b001), .TIMEOUT(64)) dut_a (
        .clk(clk), .reset(rst_n), .start(start_a),
        .vec_nk(vec_nk_a), .vec_addr(vec_addr_a),
        .vec_key(vec_key_a), .vec_pt(vec_pt_a), .vec_ct(vec_ct_a),
        .core_start(core_start_a), .core_decrypt(core_decrypt_a), .core_nk(core_nk_a),
        .core_key(core_key_a), .core_din(core_din_a),
        .core_done(core_done_a), .core_dout(core_dout_a),
        .busy(busy_a), .done(done_a), .pass_encrypt(pass_e_a), .pass_decrypt(pass_d_a),
        .fail_count(fail_count_a), .fail_vec(fail_vec_a), .timeout(timeout_a)
    );

    aes_selftest_sequencer #(.NUM_VECTORS(4), .ADDR_W(2), .NK_MASK(3'b111), .TIMEOUT(64)) dut_b (
        .clk(clk), .reset(rst_n), .start(start_b),
        .vec_nk(vec_nk_b), .vec_addr(vec_addr_b),
        .vec_key(vec_key_b), .vec_pt(vec_pt_b), .vec_ct(vec_ct_b),
        .core_start(core_start_b), .core_decrypt(core_decrypt_b), .core_nk(core_nk_b),
        .core_key(core_key_b), .core_din(core_din_b),
        .core_done(core_done_b), .core_dout(core_dout_b),
        .busy(busy_b), .done(done_b), .pass_encrypt(pass_e_b), .pass_decrypt(pass_d_b),
        .fail_count(fail_count_b), .fail_vec(fail_vec_b), .timeout(timeout_b)
    );

    // ---------------- Known-answer tables (FIPS-197 at index 0, SP800-38A ECB after) ----------------
    function automatic logic [127:0] rom_pt(input int i);
        case (i)
            0:       return 128'h00112233445566778899aabbccddeeff;
            1:       return 128'h6bc1bee22e409f96e93d7e117393172a;
            2:       return 128'hae2d8a571e03ac9c9eb76fac45af8e51;
            default: return 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        endcase
    endfunction

    function automatic logic [255:0] rom_key(input int nk, input int i);
        if (i == 0) begin
            case (nk)
                0:       return {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
                1:       return {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
                default: return 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
            endcase
        end
        case (nk)
            0:       return {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
            1:       return {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
            default: return 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        endcase
    endfunction

    function automatic logic [127:0] rom_ct(input int nk, input int i);
        case (nk)
            0: case (i)
                0:       return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
                1:       return 128'h3ad77bb40d7a3660a89ecaf32466ef97;
                2:       return 128'hf5d3d58503b9699de785895a96fdbaaf;
                default: return 128'h43b1cd7f598ece23881b00e3ed030688;
            endcase
            1: case (i)
                0:       return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
                1:       return 128'hbd334f1d6e45f25ff712a214571fa5cc;
                2:       return 128'h974104846d0ad3ad7734ecb3ecee4eef;
                default: return 128'hef7afd2270e2e60adce0ba2face6444e;
            endcase
            default: case (i)
                0:       return 128'h8ea2b7ca516745bfeafc49904b496089;
                1:       return 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
                2:       return 128'h591ccb10d410ed26dc5ba74a31362870;
                default: return 128'hb6ed21b99ca6f4f9f153e7b1beafed1d;
            endcase
        endcase
    endfunction

    // Behavioural core: answers from the true tables; unknown input returns ~din.
    function automatic logic [127:0] core_fn(input logic [1:0] nk, input logic dec, input logic [127:0] din);
        for (int i = 0; i < 4; i++) begin
            if (!dec && rom_pt(i) == din) return rom_ct(int'(nk), i);
            if (dec && rom_ct(int'(nk), i) == din) return rom_pt(i);
        end
        return ~din;
    endfunction

    always_comb begin
        vec_key_a = rom_key(int'(vec_nk_a), int'(vec_addr_a));
        vec_pt_a  = rom_pt(int'(vec_addr_a));
        vec_ct_a  = rom_ct(int'(vec_nk_a), int'(vec_addr_a));
        vec_key_b = rom_key(int'(vec_nk_b), int'(vec_addr_b));
        vec_pt_b  = rom_pt(int'(vec_addr_b));
        vec_ct_b  = rom_ct(int'(vec_nk_b), int'(vec_addr_b))
                    ^ {127'h0, (corrupt_b && vec_nk_b == 2'd1 && vec_addr_b == 2'd2)};
    end

    // ---------------- Core models, driven on the falling edge ----------------
    int           cnt_a = 0, cs_cnt_a = 0, hold_err_a = 0;
    logic [127:0] resp_a, hd_a;
    logic [255:0] hk_a;
    logic [1:0]   hn_a;
    logic         hx_a;

    always @(negedge clk) begin
        if (!rst_n) begin
            cnt_a   = 0;
            mdone_a = 1'b0;
        end else begin
            mdone_a = 1'b0;
            if (cnt_a > 0) begin
                if (core_key_a !== hk_a || core_din_a !== hd_a || core_nk_a !== hn_a || core_decrypt_a !== hx_a)
                    hold_err_a++;
                cnt_a--;
                if (cnt_a == 0) begin
                    mdone_a     = 1'b1;
                    core_dout_a = resp_a;
                end
            end
            if (core_start_a) begin
                cs_cnt_a++;
                cnt_a  = LAT;
                resp_a = core_fn(core_nk_a, core_decrypt_a, core_din_a);
                hk_a = core_key_a; hd_a = core_din_a; hn_a = core_nk_a; hx_a = core_decrypt_a;
            end
        end
    end

    int           cnt_b = 0, cs_cnt_b = 0, hold_err_b = 0;
    logic [127:0] resp_b, hd_b;
    logic [255:0] hk_b;
    logic [1:0]   hn_b;
    logic         hx_b;
    logic [1:0]   nk_log [64];
    logic         dec_log [64];

    always @(negedge clk) begin
        if (!rst_n) begin
            cnt_b       = 0;
            core_done_b = 1'b0;
        end else begin
            core_done_b = 1'b0;
            if (cnt_b > 0) begin
                if (core_key_b !== hk_b || core_din_b !== hd_b || core_nk_b !== hn_b || core_decrypt_b !== hx_b)
                    hold_err_b++;
                cnt_b--;
                if (cnt_b == 0) begin
                    core_done_b = 1'b1;
                    core_dout_b = resp_b;
                end
            end
            if (core_start_b) begin
                nk_log[cs_cnt_b % 64]  = core_nk_b;
                dec_log[cs_cnt_b % 64] = core_decrypt_b;
                cs_cnt_b++;
                if (!(hang_b && core_nk_b == 2'd0 && !core_decrypt_b && core_din_b == rom_pt(1))) begin
                    cnt_b  = LAT;
                    resp_b = core_fn(core_nk_b, core_decrypt_b, core_din_b);
                    hk_b = core_key_b; hd_b = core_din_b; hn_b = core_nk_b; hx_b = core_decrypt_b;
                end
            end
        end
    end

    // ---------------- Helpers ----------------
    // Pulses start in cycle 0 and returns the cycle index in which done is first seen.
    task automatic run_dut(input int which, input int limit, output int cycles);
        @(negedge clk);
        if (which == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        cycles = 1;
        while (!((which == 0) ? done_a : done_b) && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        #1 rst_n = 1'b0;
        #3;
        vectors++;
        if ({busy_a, done_a, pass_e_a, pass_d_a, timeout_a, fail_count_a, fail_vec_a, core_start_a} !== '0) begin
            errs++; $display("FAIL reset_status_a: got %0h expected 0",
                {busy_a, done_a, pass_e_a, pass_d_a, timeout_a, fail_count_a, fail_vec_a, core_start_a});
        end
        vectors++;
        if ({busy_b, done_b, pass_e_b, pass_d_b, timeout_b, fail_count_b, fail_vec_b, core_start_b} !== '0) begin
            errs++; $display("FAIL reset_status_b: got %0h expected 0",
                {busy_b, done_b, pass_e_b, pass_d_b, timeout_b, fail_count_b, fail_vec_b, core_start_b});
        end
        vectors++;
        if ({core_key_b, core_din_b, core_nk_b, core_decrypt_b, vec_nk_b, vec_addr_b} !== '0) begin
            errs++; $display("FAIL reset_core_b: got nonzero core/vec outputs expected 0");
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_golden_a(input string tag);
        int cyc;
        int base;
        int hbase;
        base  = cs_cnt_a;
        hbase = hold_err_a;
        run_dut(0, 100, cyc);
        vectors++;
        if (cyc !== 25) begin errs++; $display("FAIL %s_latency: got %0d cycles expected 25", tag, cyc); end
        vectors++;
        if (done_a !== 1'b1 || busy_a !== 1'b0) begin
            errs++; $display("FAIL %s_done_busy: got %b%b expected 10", tag, done_a, busy_a);
        end
        vectors++;
        if (pass_e_a !== 1'b1 || pass_d_a !== 1'b1) begin
            errs++; $display("FAIL %s_pass: got %b%b expected 11", tag, pass_e_a, pass_d_a);
        end
        vectors++;
        if (fail_count_a !== 8'd0 || timeout_a !== 1'b0 || fail_vec_a !== 2'd0) begin
            errs++; $display("FAIL %s_fails: got count %0d timeout %b vec %0d expected 0 0 0",
                tag, fail_count_a, timeout_a, fail_vec_a);
        end
        vectors++;
        if (cs_cnt_a - base !== 2) begin
            errs++; $display("FAIL %s_starts: got %0d core starts expected 2", tag, cs_cnt_a - base);
        end
        vectors++;
        if (hold_err_a - hbase !== 0) begin
            errs++; $display("FAIL %s_hold: got %0d unstable core input cycles expected 0", tag, hold_err_a - hbase);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (done_a !== 1'b1 || pass_e_a !== 1'b1 || pass_d_a !== 1'b1) begin
            errs++; $display("FAIL %s_hold_result: got done %b pass %b%b expected 1 11", tag, done_a, pass_e_a, pass_d_a);
        end
    endtask

    task automatic test_golden();
        check_golden_a("golden");
    endtask

    task automatic test_all_sizes();
        int cyc;
        int base;
        int hbase;
        base  = cs_cnt_b;
        hbase = hold_err_b;
        run_dut(1, 1000, cyc);
        vectors++;
        if (cyc !== 289) begin errs++; $display("FAIL all_latency: got %0d cycles expected 289", cyc); end
        vectors++;
        if (cs_cnt_b - base !== 24) begin
            errs++; $display("FAIL all_starts: got %0d core starts expected 24", cs_cnt_b - base);
        end
        for (int k = 0; k < 24; k++) begin
            vectors++;
            if (nk_log[(base + k) % 64] !== 2'(k / 8) || dec_log[(base + k) % 64] !== 1'(k % 2)) begin
                errs++; $display("FAIL all_seq[%0d]: got nk %0d dec %b expected nk %0d dec %0d",
                    k, nk_log[(base + k) % 64], dec_log[(base + k) % 64], k / 8, k % 2);
            end
        end
        vectors++;
        if (pass_e_b !== 1'b1 || pass_d_b !== 1'b1 || fail_count_b !== 8'd0 || timeout_b !== 1'b0) begin
            errs++; $display("FAIL all_result: got pass %b%b count %0d timeout %b expected 11 0 0",
                pass_e_b, pass_d_b, fail_count_b, timeout_b);
        end
        vectors++;
        if (hold_err_b - hbase !== 0) begin
            errs++; $display("FAIL all_hold: got %0d unstable core input cycles expected 0", hold_err_b - hbase);
        end
    endtask

    task automatic test_corrupt_ct();
        int cyc;
        corrupt_b = 1'b1;
        run_dut(1, 1000, cyc);
        corrupt_b = 1'b0;
        vectors++;
        if (cyc !== 289) begin errs++; $display("FAIL corrupt_latency: got %0d cycles expected 289", cyc); end
        vectors++;
        if (pass_e_b !== 1'b0 || pass_d_b !== 1'b0) begin
            errs++; $display("FAIL corrupt_pass: got %b%b expected 00", pass_e_b, pass_d_b);
        end
        vectors++;
        if (fail_count_b !== 8'd2) begin errs++; $display("FAIL corrupt_count: got %0d expected 2", fail_count_b); end
        vectors++;
        if (fail_vec_b !== 2'd2) begin errs++; $display("FAIL corrupt_vec: got %0d expected 2", fail_vec_b); end
        vectors++;
        if (timeout_b !== 1'b0) begin errs++; $display("FAIL corrupt_timeout: got %b expected 0", timeout_b); end
    endtask

    task automatic test_core_hang();
        int cyc;
        int base;
        base   = cs_cnt_b;
        hang_b = 1'b1;
        run_dut(1, 1000, cyc);
        hang_b = 1'b0;
        vectors++;
        if (cyc !== 343) begin errs++; $display("FAIL hang_latency: got %0d cycles expected 343", cyc); end
        vectors++;
        if (timeout_b !== 1'b1) begin errs++; $display("FAIL hang_timeout: got %b expected 1", timeout_b); end
        vectors++;
        if (fail_count_b !== 8'd1 || fail_vec_b !== 2'd1) begin
            errs++; $display("FAIL hang_count_vec: got %0d/%0d expected 1/1", fail_count_b, fail_vec_b);
        end
        vectors++;
        if (pass_e_b !== 1'b0 || pass_d_b !== 1'b1) begin
            errs++; $display("FAIL hang_pass: got %b%b expected 01", pass_e_b, pass_d_b);
        end
        vectors++;
        if (cs_cnt_b - base !== 24 || dec_log[(base + 3) % 64] !== 1'b1 || nk_log[(base + 3) % 64] !== 2'd0) begin
            errs++; $display("FAIL hang_dec_issued: got %0d starts, entry3 dec %b nk %0d expected 24 1 0",
                cs_cnt_b - base, dec_log[(base + 3) % 64], nk_log[(base + 3) % 64]);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (!(core_decrypt_a && !core_start_a) && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 100) begin errs++; $display("FAIL midrst_reach_dec_wait: got timeout expected DEC_WAIT"); end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy_a, done_a, pass_e_a, pass_d_a, timeout_a, fail_count_a, fail_vec_a} !== '0) begin
            errs++; $display("FAIL midrst_status: got %0h expected 0",
                {busy_a, done_a, pass_e_a, pass_d_a, timeout_a, fail_count_a, fail_vec_a});
        end
        vectors++;
        if ({core_start_a, core_decrypt_a, core_nk_a, vec_nk_a, vec_addr_a} !== '0) begin
            errs++; $display("FAIL midrst_ctrl: got %0h expected 0",
                {core_start_a, core_decrypt_a, core_nk_a, vec_nk_a, vec_addr_a});
        end
        vectors++;
        if (core_key_a !== '0 || core_din_a !== '0) begin
            errs++; $display("FAIL midrst_data: got key %0h din %0h expected 0", core_key_a, core_din_a);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check_golden_a("midrst_rerun");
    endtask

    task automatic test_ignore_rules();
        int cyc;
        int base;
        base = cs_cnt_a;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        spur_a  = 1'b1;
        cyc = 1;
        while (!done_a && cyc < 100) begin
            @(negedge clk);
            cyc++;
            spur_a  = 1'b0;
            start_a = (cyc == 5);
        end
        start_a = 1'b0;
        vectors++;
        if (cyc !== 25) begin errs++; $display("FAIL ignore_latency: got %0d cycles expected 25", cyc); end
        vectors++;
        if (cs_cnt_a - base !== 2) begin
            errs++; $display("FAIL ignore_starts: got %0d core starts expected 2", cs_cnt_a - base);
        end
        vectors++;
        if (pass_e_a !== 1'b1 || pass_d_a !== 1'b1 || fail_count_a !== 8'd0 || timeout_a !== 1'b0) begin
            errs++; $display("FAIL ignore_result: got pass %b%b count %0d timeout %b expected 11 0 0",
                pass_e_a, pass_d_a, fail_count_a, timeout_a);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (busy_a !== 1'b0 || done_a !== 1'b1) begin
            errs++; $display("FAIL ignore_no_restart: got busy %b done %b expected 0 1", busy_a, done_a);
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_all_sizes();
        test_corrupt_ct();
        test_core_hang();
        test_reset_mid_run();
        test_ignore_rules();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
